// File: rtl/casi_set_ctrl.sv
// Time-setting controller for the 4-digit clock: button debounce, hour/minute edit FSM,
// blink mask and load strobe. Define AUTO_REPEAT_EN to enable INC auto-repeat while held.
module casi_set_ctrl #(
    parameter int DEB_CYCLES     = 1000000,
    parameter int BLINK_CYCLES   = 12500000,
    parameter int TIMEOUT_CYCLES = 1500000000,
    parameter int REPEAT_DLY     = 25000000,
    parameter int REPEAT_PER     = 7500000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode_n,
    input  logic       btn_inc_n,
    input  logic [3:0] cur_min_u,
    input  logic [3:0] cur_min_t,
    input  logic [3:0] cur_hr_u,
    input  logic [3:0] cur_hr_t,
    output logic [3:0] set_min_u,
    output logic [3:0] set_min_t,
    output logic [3:0] set_hr_u,
    output logic [3:0] set_hr_t,
    output logic       load,
    output logic       sec_clr,
    output logic [3:0] digit_blank,
    output logic [1:0] mode
);

    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int BLK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_CYCLES - 1);
    localparam logic [30:0]      TO_LAST  = 31'(TIMEOUT_CYCLES - 1);

    // Elaboration-time sanity check on the timing parameters.
    if (DEB_CYCLES < 1 || BLINK_CYCLES < 1 || TIMEOUT_CYCLES < 1 ||
        REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_check
        $error("casi_set_ctrl: all cycle parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [1:0] btn_raw;
    logic [1:0] press_ev;
    logic       mode_ev, inc_press, inc_ev, any_ev, editing, timeout_hit;
    logic       hr_step, min_step;

    assign btn_raw = {btn_inc_n, btn_mode_n};

    // Per button: 2-flop synchronizer, stability counter, press-edge detector.
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic             sync1_reg, sync2_reg, deb_reg, deb_d_reg;
        logic [DEB_W-1:0] cnt_reg;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync1_reg <= 1'b1;
                sync2_reg <= 1'b1;
                deb_reg   <= 1'b1;
                deb_d_reg <= 1'b1;
                cnt_reg   <= '0;
            end else begin
                sync1_reg <= btn_raw[gi];
                sync2_reg <= sync1_reg;
                deb_d_reg <= deb_reg;
                if (sync2_reg == deb_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == DEB_LAST) begin
                    deb_reg <= sync2_reg;
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end

        assign press_ev[gi] = deb_d_reg & ~deb_reg;
    end

    assign mode_ev   = press_ev[0];
    assign inc_press = press_ev[1];
    assign editing   = (state_reg == ST_SET_HR) || (state_reg == ST_SET_MIN);

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DLY);
    localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PER);

    logic             rep_arm_reg, rep_first_reg, rep_fire, inc_released;
    logic [REP_W-1:0] rep_cnt_reg;

    assign inc_released = g_btn[1].deb_reg;
    assign rep_fire = rep_arm_reg &&
                      (rep_cnt_reg == (rep_first_reg ? REP_FIRST : REP_NEXT));

    // rep_cnt_reg counts cycles since the last real or synthetic increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_arm_reg   <= 1'b0;
            rep_first_reg <= 1'b0;
            rep_cnt_reg   <= '0;
        end else if (editing && inc_press && !mode_ev) begin
            rep_arm_reg   <= 1'b1;
            rep_first_reg <= 1'b1;
            rep_cnt_reg   <= REP_W'(1);
        end else if (!editing || mode_ev || inc_released || state_next != state_reg) begin
            rep_arm_reg   <= 1'b0;
            rep_first_reg <= 1'b0;
            rep_cnt_reg   <= '0;
        end else if (rep_fire) begin
            rep_first_reg <= 1'b0;
            rep_cnt_reg   <= REP_W'(1);
        end else if (rep_arm_reg) begin
            rep_cnt_reg   <= rep_cnt_reg + 1'b1;
        end
    end

    assign inc_ev = inc_press | rep_fire;
`else
    assign inc_ev = inc_press;
`endif

    assign any_ev   = mode_ev | inc_ev;
    assign hr_step  = (state_reg == ST_SET_HR)  && inc_ev && !mode_ev;
    assign min_step = (state_reg == ST_SET_MIN) && inc_ev && !mode_ev;

    logic [30:0]      to_cnt_reg;
    logic [BLK_W-1:0] blk_cnt_reg;
    logic             blk_phase_reg;

    assign timeout_hit = (to_cnt_reg == TO_LAST) && !any_ev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_RUN;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:     if (mode_ev) state_next = ST_SET_HR;
            ST_SET_HR:  if (mode_ev) state_next = ST_SET_MIN;
                        else if (timeout_hit) state_next = ST_RUN;
            ST_SET_MIN: if (mode_ev) state_next = ST_COMMIT;
                        else if (timeout_hit) state_next = ST_RUN;
            default:    state_next = ST_RUN;
        endcase
    end

    always_comb begin
        mode        = state_reg;
        load        = (state_reg == ST_COMMIT);
        sec_clr     = (state_reg == ST_COMMIT);
        digit_blank = 4'b0000;
        if (blk_phase_reg) begin
            if (state_reg == ST_SET_HR)  digit_blank = 4'b1100;
            if (state_reg == ST_SET_MIN) digit_blank = 4'b0011;
        end
    end

    // Idle timeout and blink phase only run while editing; both restart on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_reg    <= '0;
            blk_cnt_reg   <= '0;
            blk_phase_reg <= 1'b0;
        end else begin
            if (!editing || any_ev) to_cnt_reg <= '0;
            else                    to_cnt_reg <= to_cnt_reg + 1'b1;

            if (!editing || inc_ev) begin
                blk_cnt_reg   <= '0;
                blk_phase_reg <= 1'b0;
            end else if (blk_cnt_reg == BLK_LAST) begin
                blk_cnt_reg   <= '0;
                blk_phase_reg <= ~blk_phase_reg;
            end else begin
                blk_cnt_reg   <= blk_cnt_reg + 1'b1;
            end
        end
    end

    logic [3:0] hr_t_reg, hr_u_reg, min_t_reg, min_u_reg;
    logic [3:0] hr_t_next, hr_u_next, min_t_next, min_u_next;
    logic       hr_valid, min_valid;

    // BCD increment; anything out of range or at the top wraps to 00.
    always_comb begin
        hr_valid   = (hr_t_reg < 4'd2 && hr_u_reg <= 4'd9) || (hr_t_reg == 4'd2 && hr_u_reg <= 4'd3);
        min_valid  = (min_t_reg <= 4'd5) && (min_u_reg <= 4'd9);
        hr_t_next  = hr_t_reg;
        hr_u_next  = hr_u_reg + 4'd1;
        min_t_next = min_t_reg;
        min_u_next = min_u_reg + 4'd1;
        if (!hr_valid || (hr_t_reg == 4'd2 && hr_u_reg == 4'd3)) begin
            hr_t_next = 4'd0;
            hr_u_next = 4'd0;
        end else if (hr_u_reg == 4'd9) begin
            hr_t_next = hr_t_reg + 4'd1;
            hr_u_next = 4'd0;
        end
        if (!min_valid || (min_t_reg == 4'd5 && min_u_reg == 4'd9)) begin
            min_t_next = 4'd0;
            min_u_next = 4'd0;
        end else if (min_u_reg == 4'd9) begin
            min_t_next = min_t_reg + 4'd1;
            min_u_next = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hr_t_reg  <= '0;
            hr_u_reg  <= '0;
            min_t_reg <= '0;
            min_u_reg <= '0;
        end else if (state_reg == ST_RUN && mode_ev) begin
            hr_t_reg  <= cur_hr_t;
            hr_u_reg  <= cur_hr_u;
            min_t_reg <= cur_min_t;
            min_u_reg <= cur_min_u;
        end else begin
            if (hr_step) begin
                hr_t_reg <= hr_t_next;
                hr_u_reg <= hr_u_next;
            end
            if (min_step) begin
                min_t_reg <= min_t_next;
                min_u_reg <= min_u_next;
            end
        end
    end

    assign set_hr_t  = hr_t_reg;
    assign set_hr_u  = hr_u_reg;
    assign set_min_t = min_t_reg;
    assign set_min_u = min_u_reg;

endmodule

// File: tb/tb_casi_set_ctrl.sv
// Directed bench for casi_set_ctrl: expected load values go into a scoreboard queue
// that a free-running monitor pops whenever the DUT strobes load.
module tb_casi_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_mode_n = 1'b1;
    logic       btn_inc_n = 1'b1;
    logic [3:0] cur_min_u = 4'd0, cur_min_t = 4'd4, cur_hr_u = 4'd2, cur_hr_t = 4'd1;
    logic [3:0] set_min_u, set_min_t, set_hr_u, set_hr_t;
    logic       load, sec_clr;
    logic [3:0] digit_blank;
    logic [1:0] mode;

    always #5 clk = ~clk;

    casi_set_ctrl #(
        .DEB_CYCLES    (4),
        .BLINK_CYCLES  (8),
        .TIMEOUT_CYCLES(200),
        .REPEAT_DLY    (20),
        .REPEAT_PER    (5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode_n (btn_mode_n),
        .btn_inc_n  (btn_inc_n),
        .cur_min_u  (cur_min_u),
        .cur_min_t  (cur_min_t),
        .cur_hr_u   (cur_hr_u),
        .cur_hr_t   (cur_hr_t),
        .set_min_u  (set_min_u),
        .set_min_t  (set_min_t),
        .set_hr_u   (set_hr_u),
        .set_hr_t   (set_hr_t),
        .load       (load),
        .sec_clr    (sec_clr),
        .digit_blank(digit_blank),
        .mode       (mode)
    );

    int          total = 0;
    int          bad = 0;
    int          loads_seen = 0;
    int          age = 0;
    int          last_min_age = -1;
    logic [1:0]  prev_mode = 2'd0;
    logic        prev_load = 1'b0;
    logic [15:0] exp_val;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int setv();
        return int'({set_hr_t, set_hr_u, set_min_t, set_min_u});
    endfunction

    task automatic set_cur(input logic [15:0] t);
        {cur_hr_t, cur_hr_u, cur_min_t, cur_min_u} = t;
    endtask

    // Press one or both buttons for 10 cycles, then release and let it settle.
    task automatic press(input bit m, input bit i);
        @(negedge clk);
        if (m) btn_mode_n = 1'b0;
        if (i) btn_inc_n = 1'b0;
        repeat (10) @(negedge clk);
        btn_mode_n = 1'b1;
        btn_inc_n  = 1'b1;
        repeat (12) @(negedge clk);
        $display("press mode=%0d inc=%0d -> mode=%0d set=%04h", m, i, mode, setv());
    endtask

    // Monitor: pops the scoreboard on each load strobe and tracks time spent per mode.
    initial begin
        forever begin
            @(negedge clk);
            if (load || sec_clr) begin
                check("sec_clr_with_load", sec_clr, load);
                check("load_one_cycle", prev_load, 0);
                check("load_expected", int'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_val = exp_q.pop_front();
                    check("load_value", setv(), exp_val);
                end
                loads_seen++;
                $display("load seen set=%04h sec_clr=%0d", setv(), sec_clr);
            end
            prev_load = load;
            if (mode != prev_mode) begin
                if (prev_mode == 2'd2 && mode == 2'd0) last_min_age = age;
                age = 1;
            end else begin
                age++;
            end
            prev_mode = mode;
        end
    end

    initial begin
        int   n;
        int   last;
        int   ntrans;
        bit   seen;
        logic [3:0] v, pv;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_mode", mode, 0);
        check("rst_load", load, 0);
        check("rst_sec_clr", sec_clr, 0);
        check("rst_blank", digit_blank, 0);
        check("rst_set", setv(), 0);

        // INC in RUN is ignored.
        press(0, 1);
        press(0, 1);
        check("run_inc_mode", mode, 0);
        check("run_inc_set", setv(), 0);

        // 12:40 -> 15:42 and commit.
        press(1, 0);
        check("enter_hr_mode", mode, 1);
        check("capture", setv(), 16'h1240);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (digit_blank == 4'b1100) seen = 1'b1;
        end
        check("hr_blink_seen", seen, 1);
        repeat (3) press(0, 1);
        check("hr_plus3", setv(), 16'h1540);
        press(1, 0);
        check("enter_min_mode", mode, 2);
        repeat (2) press(0, 1);
        check("min_plus2", setv(), 16'h1542);
        exp_q.push_back(16'h1542);
        press(1, 0);
        check("commit_back_run", mode, 0);

        // Wraps: 22 -> 23 -> 00, 58 -> 59 -> 00 with no carry into hours.
        set_cur(16'h2258);
        press(1, 0);
        press(0, 1);
        check("hr_23", setv(), 16'h2358);
        press(0, 1);
        check("hr_wrap", setv(), 16'h0058);
        press(1, 0);
        press(0, 1);
        check("min_59", setv(), 16'h0059);
        press(0, 1);
        check("min_wrap", setv(), 16'h0000);
        exp_q.push_back(16'h0000);
        press(1, 0);
        check("wrap_back_run", mode, 0);

        // Glitch shorter than the debounce window, then a real hold.
        set_cur(16'h1240);
        press(1, 0);
        @(negedge clk);
        btn_inc_n = 1'b0;
        repeat (3) @(negedge clk);
        btn_inc_n = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_ignored", setv(), 16'h1240);
        btn_inc_n = 1'b0;
        repeat (10) @(negedge clk);
        btn_inc_n = 1'b1;
        repeat (15) @(negedge clk);
        check("hold_one_inc", setv(), 16'h1340);

        // SET_MIN blink cadence, then idle timeout with no load.
        press(1, 0);
        check("timeout_enter_min", mode, 2);
        pv = digit_blank;
        last = -1;
        ntrans = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            v = digit_blank;
            if (v != pv) begin
                check("min_blink_value", int'(v == 4'b0011 || v == 4'b0000), 1);
                if (last >= 0) check("min_blink_period", k - last, 8);
                last = k;
                ntrans++;
            end
            pv = v;
        end
        check("min_blink_toggles", int'(ntrans >= 11), 1);
        n = 0;
        while (mode != 2'd0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("timeout_mode", mode, 0);
        @(negedge clk);
        check("timeout_cycles", last_min_age, 200);
        check("timeout_set_hold", setv(), 16'h1340);

        // MODE and INC in the same cycle: MODE wins.
        set_cur(16'h1240);
        press(1, 0);
        press(1, 1);
        check("both_mode", mode, 2);
        check("both_hr_same", setv(), 16'h1240);
`ifdef AUTO_REPEAT_EN
        @(negedge clk);
        btn_inc_n = 1'b0;
        repeat (40) @(negedge clk);
        btn_inc_n = 1'b1;
        repeat (15) @(negedge clk);
        check("auto_repeat", setv(), 16'h1245);
        exp_q.push_back(16'h1245);
`else
        press(0, 1);
        check("single_inc", setv(), 16'h1241);
        exp_q.push_back(16'h1241);
`endif
        press(1, 0);
        check("both_back_run", mode, 0);

        // Reset mid-edit: straight back to RUN, no load.
        set_cur(16'h0915);
        press(1, 0);
        check("mid_edit_mode", mode, 1);
        check("mid_edit_capture", setv(), 16'h0915);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_mode", mode, 0);
        check("mid_rst_set", setv(), 0);
        check("mid_rst_blank", digit_blank, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        check("pending_loads", exp_q.size(), 0);
        check("loads_seen", loads_seen, 3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/casi_set_ctrl.md
Name: casi_set_ctrl

Overview:
- Time-setting controller for the 4-digit 7-segment clock.
- Debounces two push-buttons, MODE and INC, and runs a set-mode FSM that edits hours and then minutes, starting from the live time.
- Drives a blink/blank mask to the display multiplexer so the field being edited flashes.
- Issues a one-cycle load strobe that writes the edited BCD digits into the timekeeper counters.

Parameters:
- DEB_CYCLES, 1000000: clk cycles a synchronized button level must stay stable before it is accepted (20 ms at 50 MHz).
- BLINK_CYCLES, 12500000: half-period of the edit-field blink (4 Hz toggle → 2 Hz flash).
- TIMEOUT_CYCLES, 1500000000: idle cycles in a SET state before abandoning the edit (30 s). Counter width 31 bits.
- REPEAT_DLY, 25000000: INC hold time before auto-repeat starts (AUTO_REPEAT_EN only).
- REPEAT_PER, 7500000: auto-repeat period (AUTO_REPEAT_EN only).

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- btn_mode_n  in  1  raw MODE button, active-low, asynchronous to clk
- btn_inc_n  in  1  raw INC button, active-low, asynchronous to clk
- cur_min_u  in  4  live minute units (BCD) from timekeeper
- cur_min_t  in  4  live minute tens
- cur_hr_u  in  4  live hour units
- cur_hr_t  in  4  live hour tens
- set_min_u  out  4  edited minute units
- set_min_t  out  4  edited minute tens
- set_hr_u  out  4  edited hour units
- set_hr_t  out  4  edited hour tens
- load  out  1  one-cycle strobe; timekeeper copies set_* on this cycle
- sec_clr  out  1  one-cycle strobe coincident with load; clears seconds prescaler and blink phase
- digit_blank  out  4  1 = blank digit; bit0 min units, bit1 min tens, bit2 hr units, bit3 hr tens
- mode  out  2  0 RUN, 1 SET_HR, 2 SET_MIN, 3 COMMIT

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; FSM in RUN; edit registers 0.
  - Synchronizer flops at 1 (released); debounced levels at released; all counters 0.
- Button path:
  - 2-flop synchronizer, then stability counter.
  - Debounced level updates once the synchronized level has differed from it for DEB_CYCLES consecutive cycles.
  - Press event: one-cycle pulse on the debounced released→pressed transition. Releases generate no event.
  - Event appears at most DEB_CYCLES+3 cycles after the raw input settles low.
- FSM; transitions take effect the cycle after the event:
  - RUN + mode_ev → SET_HR. Same edge captures cur_* into edit registers; timeout counter and blink phase cleared (phase starts blanking=0).
  - SET_HR + inc_ev → hours +1 in BCD, 00..23, 23 → 00. Units roll 9 → 0 with tens +1; 19 → 20.
  - SET_HR + mode_ev → SET_MIN.
  - SET_MIN + inc_ev → minutes +1 in BCD, 00..59, 59 → 00. No carry into hours.
  - SET_MIN + mode_ev → COMMIT.
  - COMMIT: load=1 and sec_clr=1 for exactly one cycle, then → RUN unconditionally.
  - SET_HR/SET_MIN with no press event for TIMEOUT_CYCLES → RUN. No load; edits discarded.
  - Timeout counter clears on any press event.
- Simultaneous mode_ev and inc_ev in the same cycle: MODE wins; INC is dropped.
- inc_ev in RUN or COMMIT: ignored.
- Out-of-range captured value (e.g. hr 27): the first INC wraps to 00.
- set_* hold their last edited value in RUN. They are meaningful only while load=1.
- digit_blank:
  - RUN/COMMIT: 0000.
  - SET_HR: 1100 during the blink-phase high half, else 0000.
  - SET_MIN: 0011 during the high half, else 0000.
  - Blink phase resets to low on every inc_ev, so the digit is visible right after a change.
- rst_n asserted mid-edit: immediate return to RUN; no load pulse; timekeeper untouched.

Optional Feature:
- Macro AUTO_REPEAT_EN.
  - Defined: while the debounced INC stays pressed in SET_HR/SET_MIN, the first synthetic inc_ev fires REPEAT_DLY cycles after the press event, then one every REPEAT_PER cycles until release. Synthetic events follow all normal rules: MODE priority, timeout clear, blink reset. Release or a state change stops the repeat.
  - Undefined: exactly one increment per press; REPEAT_* parameters unused.

Test Plan (bench overrides: DEB_CYCLES=4, BLINK_CYCLES=8, TIMEOUT_CYCLES=200, REPEAT_DLY=20, REPEAT_PER=5):
- Reset then idle; cur_*=12:40 → all outputs 0, mode=0; INC presses leave mode=0 and load=0.
- MODE press with cur=12:40, 3 INC, MODE, 2 INC, MODE → load pulses once for 1 cycle with set=15:42 and sec_clr=1; mode returns to 0.
- cur=22:58, enter SET_HR, 2 INC → hr 00; MODE, 2 INC → min 00, hours still 00; commit gives set=00:00.
- Glitch: btn_inc_n low for 3 cycles then high → no event. Held low 10 cycles → exactly one increment.
- Enter SET_MIN, no presses for 200 cycles → mode=0, no load. digit_blank toggles 0011/0000 every 8 cycles before the timeout.
- Both buttons pressed in the same cycle in SET_HR → goes to SET_MIN, hours unchanged. With AUTO_REPEAT_EN, holding INC 40 cycles in SET_MIN → 1 + 1 + 3 = 5 increments.
